// File: rtl/mcu51_disp_pkg.sv
// Shared constants for the MCU51 port display: blanking values, digit count
// and the hex -> 7-segment (active-high abcdefg) lookup table.
package mcu51_disp_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Entry n is the active-high pattern for hex digit n (index 15 listed first).
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit nibble to active-high abcdefg segment pattern.
module hex_to_seg7
    import mcu51_disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG_TABLE[nibble_i];

endmodule

// File: rtl/port_display_scan.sv
// Tear-free once-per-frame snapshot of P0/P1L shown on a 4-digit multiplexed
// common-anode display. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module port_display_scan
    import mcu51_disp_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 500,
    parameter int ACT_FRAMES = 8
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [7:0] P0,
    input  logic [3:0] P1L,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_LIM = DIV_W'(BLANK_CYC);
    localparam logic [7:0]       ACT_LOAD  = 8'(ACT_FRAMES);
    localparam logic [1:0]       IDX_LAST  = 2'(NUM_DIGITS - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [11:0]      snap_q, snap_d;
    logic [7:0]       act_cnt_q, act_cnt_d;
    logic             primed_q, primed_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       an_q, an_d;
    logic             frame_tick_q, frame_tick_d;

    logic [3:0] digit_nib;
    logic [6:0] digit_seg;
    logic       digit_show;
    logic       load;
    logic [11:0] port_val;

    assign port_val = {P1L, P0};

    always_comb begin
        case (idx_q)
            2'd0:    digit_nib = snap_q[3:0];
            2'd1:    digit_nib = snap_q[7:4];
            default: digit_nib = snap_q[11:8];
        endcase
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble_i (digit_nib),
        .seg_o    (digit_seg)
    );

    always_comb begin
        digit_show = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_q == 2'd2 && snap_q[11:8] == 4'h0) digit_show = 1'b0;
        if (idx_q == 2'd1 && snap_q[11:4] == 8'h00) digit_show = 1'b0;
`endif
    end

    always_comb begin
        div_cnt_d    = div_cnt_q + 1'b1;
        idx_d        = idx_q;
        snap_d       = snap_q;
        act_cnt_d    = act_cnt_q;
        primed_d     = 1'b1;
        seg_d        = SEG_OFF;
        dp_d         = 1'b1;
        an_d         = AN_OFF;
        frame_tick_d = 1'b0;

        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            idx_d     = idx_q + 1'b1;
        end

        // First cycle out of reset loads immediately so the display is never stale.
        load = !primed_q || (div_cnt_q == DIV_LAST && idx_q == IDX_LAST);
        if (load) begin
            snap_d       = port_val;
            frame_tick_d = 1'b1;
            if (port_val != snap_q)
                act_cnt_d = ACT_LOAD;
            else if (act_cnt_q != 8'd0)
                act_cnt_d = act_cnt_q - 1'b1;
        end

        // Anti-ghost window at the start of each slot; slot 3 is the spare digit.
        if (div_cnt_q >= BLANK_LIM && idx_q != IDX_LAST && digit_show) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = ~digit_seg;
            dp_d  = !(idx_q == 2'd0 && act_cnt_q != 8'd0);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            div_cnt_q    <= '0;
            idx_q        <= 2'd0;
            snap_q       <= 12'h000;
            act_cnt_q    <= 8'd0;
            primed_q     <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            an_q         <= AN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            act_cnt_q    <= act_cnt_d;
            primed_q     <= primed_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_port_display_scan.sv
// Bench for port_display_scan with a 16-cycle frame; a cycle-indexed reference
// model pushes expected {frame_tick, an, dp, seg} that is popped after each edge.
module tb_port_display_scan;

    localparam int SD = 4;
    localparam int BC = 1;
    localparam int AF = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] p0;
    logic [3:0] p1l;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_tick;

    always #5 clk = ~clk;

    port_display_scan #(
        .SCAN_DIV   (SD),
        .BLANK_CYC  (BC),
        .ACT_FRAMES (AF)
    ) dut (
        .CLK        (clk),
        .reset      (reset),
        .P0         (p0),
        .P1L        (p1l),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    int checks = 0;
    int errors = 0;
    logic [12:0] exp_q[$];

    int          m_t;
    logic [11:0] m_snap;
    int          m_act;
    bit          m_primed;
    int          cyc = 0;
    int          last_tick = -1;
    bit          chk_period = 0;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic tick();
        logic [12:0] e;
        logic [12:0] got;
        logic [3:0]  nib;
        logic [3:0]  an_e;
        int          ph;
        int          sl;
        bit          ft;
        bit          show;
        if (reset) begin
            e        = {1'b0, 4'hF, 1'b1, 7'h7F};
            m_t      = 0;
            m_snap   = 12'h000;
            m_act    = 0;
            m_primed = 0;
        end else begin
            ph   = m_t % SD;
            sl   = (m_t / SD) % 4;
            show = 1;
`ifdef LEADING_ZERO_BLANK_EN
            if (sl == 2 && m_snap[11:8] == 4'h0) show = 0;
            if (sl == 1 && m_snap[11:4] == 8'h00) show = 0;
`endif
            nib  = (sl == 0) ? m_snap[3:0] : (sl == 1) ? m_snap[7:4] : m_snap[11:8];
            an_e = ~(4'b0001 << sl);
            ft   = !m_primed || (ph == SD - 1 && sl == 3);
            if (ph < BC || sl == 3 || !show)
                e = {ft, 4'hF, 1'b1, 7'h7F};
            else
                e = {ft, an_e, !(sl == 0 && m_act != 0), ~hex7(nib)};
            if (ft) begin
                if ({p1l, p0} != m_snap) m_act = AF;
                else if (m_act > 0)      m_act = m_act - 1;
                m_snap   = {p1l, p0};
                m_primed = 1;
            end
            m_t++;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        got = {frame_tick, an, dp, seg};
        check_eq("out", {3'b0, got}, {3'b0, exp_q.pop_front()});
        if (frame_tick) begin
            if (chk_period && last_tick >= 0)
                check_eq("period", 16'(cyc - last_tick), 16'd16);
            last_tick = cyc;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        p0    = 8'h00;
        p1l   = 4'h0;
        repeat (3) tick();
        check_eq("rst_seg", {9'b0, seg}, 16'h007F);
        check_eq("rst_an", {12'b0, an}, 16'h000F);
        check_eq("rst_dp", {15'b0, dp}, 16'h0001);
        check_eq("rst_ft", {15'b0, frame_tick}, 16'h0000);

        // Steady 0x298, then release reset
        p0    = 8'h98;
        p1l   = 4'h2;
        reset = 1'b0;
        tick();
        check_eq("first_load", {15'b0, frame_tick}, 16'h0001);
        repeat (40) tick();

        // Mid-frame change of P0
        for (int i = 0; i < 32 && (m_t % 16) != 8; i++) tick();
        p0 = 8'h12;
        repeat (64) tick();

        // Fast toggling; frame_tick must stay on a 16-cycle cadence
        chk_period = 1;
        last_tick  = -1;
        for (int i = 0; i < 64; i++) begin
            if (i % 3 == 0) p0 = 8'($urandom_range(0, 255));
            tick();
        end
        chk_period = 0;

        // Reset pulse in slot 2
        for (int i = 0; i < 32 && !(((m_t / SD) % 4) == 2 && (m_t % SD) == 1); i++) tick();
        reset = 1'b1;
        tick();
        check_eq("midrst_an", {12'b0, an}, 16'h000F);
        check_eq("midrst_seg", {9'b0, seg}, 16'h007F);
        check_eq("midrst_dp", {15'b0, dp}, 16'h0001);
        reset = 1'b0;
        tick();
        check_eq("midrst_reload", {15'b0, frame_tick}, 16'h0001);
        repeat (20) tick();

        // Leading-zero pattern
        p1l = 4'h0;
        p0  = 8'h05;
        repeat (48) tick();

        // Random traffic with occasional resets
        for (int i = 0; i < 160; i++) begin
            if (i % 5 == 0) begin
                p0  = 8'($urandom_range(0, 255));
                p1l = 4'($urandom_range(0, 15));
            end
            reset = ($urandom_range(0, 40) == 0);
            tick();
        end
        reset = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
